// File: rtl/baud_tick_gen.sv
// -----------------------------------------------------------------------------
// baud_tick_gen
//
// Runtime-programmable baud tick generator. A divider counter produces a
// one-cycle oversample tick (tick_os) every P cycles, where P is the effective
// divisor (div_act clamped to >= 2) plus an optional fractional carry. Every
// OS-th oversample tick is also flagged as a bit tick (tick_bit).
//
// A new divisor / fractional adjust is offered through a valid/ready handshake
// into a single shadow slot. The shadow is promoted to the active
// configuration at the first tick_os, en-low or sync_clr cycle, so a running
// period is never cut short by a reload.
//
// Build option:
//   BAUD_FRAC_EN  defined   -> fractional accumulator and cfg_frac path present
//                 undefined -> integer-only divider, cfg_frac ignored
//                              (port list identical in both builds)
//
// Parameters:
//   DIV_W      width of the integer divisor
//   FRAC_W     width of the fractional adjust (units of 1/2^FRAC_W cycle)
//   OS         oversample ratio, power of two, >= 2
//   DIV_RESET  divisor loaded at reset
//
// Ports:
//   clk        in   system clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   en         in   count enable; low freezes counters and suppresses ticks
//   sync_clr   in   synchronous phase clear (priority over en)
//   cfg_valid  in   new configuration offered
//   cfg_ready  out  shadow configuration slot free
//   cfg_div    in   new integer divisor
//   cfg_frac   in   new fractional adjust
//   tick_os    out  oversample tick, one cycle wide
//   tick_bit   out  bit tick, coincident with every OS-th tick_os
// -----------------------------------------------------------------------------
module baud_tick_gen #(
  parameter int DIV_W     = 16,
  parameter int FRAC_W    = 4,
  parameter int OS        = 16,
  parameter int DIV_RESET = 326
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic              sync_clr,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [FRAC_W-1:0] cfg_frac,
  output logic              tick_os,
  output logic              tick_bit
);

  localparam int OS_W = $clog2(OS);

  // Divider / phase state
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [OS_W-1:0]  os_cnt_q, os_cnt_d;

  // Active and shadow integer configuration
  logic [DIV_W-1:0] div_act_q, div_act_d;
  logic [DIV_W-1:0] div_pend_q, div_pend_d;
  logic             pend_q, pend_d;

  logic [DIV_W-1:0] div_eff;
  logic [DIV_W:0]   period_m1;
  logic             carry;
  logic             apply;
  logic             capture;

  // Divisors 0 and 1 would give a degenerate (or never-firing) counter.
  assign div_eff = (div_act_q < DIV_W'(2)) ? DIV_W'(2) : div_act_q;

  // Last count of the current period. One extra bit so that d + carry cannot
  // overflow when div_act is at its maximum value.
  assign period_m1 = {1'b0, div_eff} + {{DIV_W{1'b0}}, carry}
                   - {{DIV_W{1'b0}}, 1'b1};

  assign tick_os   = en & ~sync_clr & ({1'b0, cnt_q} == period_m1);
  assign tick_bit  = tick_os & (os_cnt_q == OS_W'(OS - 1));
  assign cfg_ready = ~pend_q;

  // Promote the shadow on any boundary where no period is in flight or the
  // counters are frozen/cleared. Capture needs pend_q low and apply needs it
  // high, so the two can never coincide.
  assign apply   = pend_q & (tick_os | ~en | sync_clr);
  assign capture = cfg_valid & ~pend_q;

  // ---------------------------------------------------------------------------
  // Divider and oversample counters
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_d    = cnt_q;
    os_cnt_d = os_cnt_q;
    if (sync_clr) begin
      cnt_d    = '0;
      os_cnt_d = '0;
    end else if (tick_os) begin
      cnt_d    = '0;
      // OS is a power of two, so the natural wrap of os_cnt is the OS wrap.
      os_cnt_d = os_cnt_q + OS_W'(1);
    end else if (en) begin
      cnt_d    = cnt_q + DIV_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Integer configuration handshake
  // ---------------------------------------------------------------------------
  always_comb begin
    div_act_d  = div_act_q;
    div_pend_d = div_pend_q;
    pend_d     = pend_q;
    if (apply) begin
      div_act_d = div_pend_q;
      pend_d    = 1'b0;
    end else if (capture) begin
      div_pend_d = cfg_div;
      pend_d     = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q      <= '0;
      os_cnt_q   <= '0;
      div_act_q  <= DIV_W'(DIV_RESET);
      div_pend_q <= '0;
      pend_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      os_cnt_q   <= os_cnt_d;
      div_act_q  <= div_act_d;
      div_pend_q <= div_pend_d;
      pend_q     <= pend_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Fractional adjust
  // ---------------------------------------------------------------------------
`ifdef BAUD_FRAC_EN
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic [FRAC_W-1:0] frac_act_q, frac_act_d;
  logic [FRAC_W-1:0] frac_pend_q, frac_pend_d;
  logic [FRAC_W:0]   frac_sum;

  // The carry of this period's accumulation stretches this period by one.
  assign frac_sum = {1'b0, acc_q} + {1'b0, frac_act_q};
  assign carry    = frac_sum[FRAC_W];

  always_comb begin
    acc_d       = acc_q;
    frac_act_d  = frac_act_q;
    frac_pend_d = frac_pend_q;
    if (sync_clr) begin
      acc_d = '0;
    end else if (tick_os) begin
      acc_d = frac_sum[FRAC_W-1:0];
    end
    if (apply) begin
      frac_act_d = frac_pend_q;
    end else if (capture) begin
      frac_pend_d = cfg_frac;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q       <= '0;
      frac_act_q  <= '0;
      frac_pend_q <= '0;
    end else begin
      acc_q       <= acc_d;
      frac_act_q  <= frac_act_d;
      frac_pend_q <= frac_pend_d;
    end
  end
`else
  // Integer-only build: every period is exactly d cycles.
  logic unused_cfg_frac;
  assign carry           = 1'b0;
  assign unused_cfg_frac = ^cfg_frac;
`endif

endmodule

// File: tb/tb_baud_tick_gen.sv
// -----------------------------------------------------------------------------
// tb_baud_tick_gen
//
// Self-checking bench for baud_tick_gen. A behavioural reference model tracks
// elapsed cycles, total accumulated fraction and total tick count as plain
// integers and predicts tick_os / tick_bit / cfg_ready. Directed scenario
// tasks also check tick intervals against values worked out from the
// divisor rules; a final task drives $urandom stimulus against the model.
// Inputs are driven and outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_baud_tick_gen;

  localparam int DIV_W     = 16;
  localparam int FRAC_W    = 4;
  localparam int OS        = 16;
  localparam int DIV_RESET = 326;
  localparam int FRAC_ONE  = 1 << FRAC_W;
  localparam int DIV_MOD   = 1 << DIV_W;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              en;
  logic              sync_clr;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [DIV_W-1:0]  cfg_div;
  logic [FRAC_W-1:0] cfg_frac;
  logic              tick_os;
  logic              tick_bit;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  baud_tick_gen #(
    .DIV_W    (DIV_W),
    .FRAC_W   (FRAC_W),
    .OS       (OS),
    .DIV_RESET(DIV_RESET)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (en),
    .sync_clr (sync_clr),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_div  (cfg_div),
    .cfg_frac (cfg_frac),
    .tick_os  (tick_os),
    .tick_bit (tick_bit)
  );

  // ---------------------------------------------------------------------------
  // Reference model: elapsed time in the current period, running totals of
  // fraction and ticks since the last phase clear, and a one-entry config slot.
  // ---------------------------------------------------------------------------
  int     m_div, m_frac, m_pdiv, m_pfrac;
  bit     m_pend;
  int     m_elapsed;
  longint m_fsum;
  longint m_ticks;
  int     m_period;
  bit     m_tick_os, m_tick_bit, m_ready;

  always_comb begin
    m_period = (m_div < 2) ? 2 : m_div;
    if (((m_fsum % FRAC_ONE) + m_frac) >= FRAC_ONE) m_period = m_period + 1;
    m_tick_os  = (en === 1'b1) && (sync_clr === 1'b0) && (m_elapsed == m_period - 1);
    m_tick_bit = m_tick_os && ((m_ticks % OS) == OS - 1);
    m_ready    = !m_pend;
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_div     <= DIV_RESET;
      m_frac    <= 0;
      m_pdiv    <= 0;
      m_pfrac   <= 0;
      m_pend    <= 1'b0;
      m_elapsed <= 0;
      m_fsum    <= 0;
      m_ticks   <= 0;
    end else begin
      if (sync_clr) begin
        m_elapsed <= 0;
        m_fsum    <= 0;
        m_ticks   <= 0;
      end else if (m_tick_os) begin
        m_elapsed <= 0;
        m_fsum    <= m_fsum + m_frac;
        m_ticks   <= m_ticks + 1;
      end else if (en) begin
        m_elapsed <= (m_elapsed + 1) % DIV_MOD;
      end
      if (m_pend && (m_tick_os || !en || sync_clr)) begin
        m_div  <= m_pdiv;
        m_frac <= m_pfrac;
        m_pend <= 1'b0;
      end else if (cfg_valid && !m_pend) begin
        m_pdiv <= int'(cfg_div);
`ifdef BAUD_FRAC_EN
        m_pfrac <= int'(cfg_frac);
`else
        m_pfrac <= 0;
`endif
        m_pend <= 1'b1;
      end
    end
  end

  // Advance falling edges until the selected tick is seen (n = cycles taken,
  // -1 on timeout); mm counts cycles where the outputs differed from the model.
  task automatic wait_evt(input bit want_bit, input int limit, output int n, output int mm);
    n  = 0;
    mm = 0;
    forever begin
      @(negedge clk);
      n++;
      if (tick_os !== m_tick_os || tick_bit !== m_tick_bit || cfg_ready !== m_ready) mm++;
      if ((want_bit ? tick_bit : tick_os) === 1'b1) break;
      if (n >= limit) begin
        n = -1;
        break;
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset_n   = 1'b0;
    en        = 1'b1;
    sync_clr  = 1'b0;
    cfg_valid = 1'b0;
    cfg_div   = '0;
    cfg_frac  = '0;
    repeat (3) @(negedge clk);
    checks += 3;
    if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", cfg_ready); end
    if (tick_os !== 1'b0) begin errors++; $display("FAIL reset_tick_os: got %b expected 0", tick_os); end
    if (tick_bit !== 1'b0) begin errors++; $display("FAIL reset_tick_bit: got %b expected 0", tick_bit); end
    $display("test_reset: ready=%b tick_os=%b tick_bit=%b", cfg_ready, tick_os, tick_bit);
  endtask

  task automatic test_default_rate();
    int n, mm;
    reset_n = 1'b1;  // this sample point is cycle 0
    wait_evt(1'b0, 400, n, mm);
    checks += 2;
    if (n !== DIV_RESET - 1) begin errors++; $display("FAIL first_tick: got %0d expected %0d", n, DIV_RESET - 1); end
    if (mm !== 0) begin errors++; $display("FAIL first_tick_model: got %0d diffs expected 0", mm); end
    wait_evt(1'b0, 400, n, mm);
    checks += 2;
    if (n !== DIV_RESET) begin errors++; $display("FAIL os_interval: got %0d expected %0d", n, DIV_RESET); end
    if (mm !== 0) begin errors++; $display("FAIL os_interval_model: got %0d diffs expected 0", mm); end
    // First bit tick lands at cycle OS*d-1; two oversample ticks already passed.
    wait_evt(1'b1, 6000, n, mm);
    checks += 2;
    if (n !== (OS - 2) * DIV_RESET) begin errors++; $display("FAIL first_bit: got %0d expected %0d", n, (OS - 2) * DIV_RESET); end
    if (mm !== 0) begin errors++; $display("FAIL first_bit_model: got %0d diffs expected 0", mm); end
    wait_evt(1'b1, 6000, n, mm);
    checks += 2;
    if (n !== OS * DIV_RESET) begin errors++; $display("FAIL bit_interval: got %0d expected %0d", n, OS * DIV_RESET); end
    if (mm !== 0) begin errors++; $display("FAIL bit_interval_model: got %0d diffs expected 0", mm); end
    $display("test_default_rate: bit interval %0d", n);
  endtask

  task automatic test_frac_cfg();
    int n, mm, exp_n;
    repeat (100) @(negedge clk);  // mid-period of the 326-cycle divisor
    cfg_valid = 1'b1;
    cfg_div   = 16'd10;
    cfg_frac  = 4'd4;
    @(negedge clk);
    cfg_valid = 1'b0;
    checks++;
    if (cfg_ready !== 1'b0) begin errors++; $display("FAIL ready_drop: got %b expected 0", cfg_ready); end
    // Old period completes at its full length: 326 - 101 cycles remain.
    wait_evt(1'b0, 400, n, mm);
    checks += 2;
    if (n !== DIV_RESET - 101) begin errors++; $display("FAIL old_period: got %0d expected %0d", n, DIV_RESET - 101); end
    if (mm !== 0) begin errors++; $display("FAIL old_period_model: got %0d diffs expected 0", mm); end
    for (int k = 0; k < 8; k++) begin
`ifdef BAUD_FRAC_EN
      exp_n = 10 + ((k + 1) * 4) / FRAC_ONE - (k * 4) / FRAC_ONE;
`else
      exp_n = 10;
`endif
      wait_evt(1'b0, 40, n, mm);
      checks += 2;
      if (n !== exp_n) begin errors++; $display("FAIL frac_period%0d: got %0d expected %0d", k, n, exp_n); end
      if (mm !== 0) begin errors++; $display("FAIL frac_period%0d_model: got %0d diffs expected 0", k, mm); end
      $display("test_frac_cfg: period %0d = %0d cycles", k, n);
    end
    checks++;
    if (cfg_ready !== 1'b1) begin errors++; $display("FAIL ready_return: got %b expected 1", cfg_ready); end
  endtask

  task automatic test_div_clamp();
    int n, mm, low, exp_first;
    for (int v = 0; v < 2; v++) begin
      // Offered on a tick cycle, so the pending slot spans the next whole period.
      exp_first = (v == 0) ? 10 : 2;
      cfg_valid = 1'b1;
      cfg_div   = DIV_W'(v);
      cfg_frac  = '0;
      @(negedge clk);
      cfg_valid = 1'b0;
      n   = 1;
      low = (cfg_ready === 1'b0) ? 1 : 0;
      mm  = (tick_os !== m_tick_os || cfg_ready !== m_ready) ? 1 : 0;
      while (tick_os !== 1'b1 && n < 50) begin
        @(negedge clk);
        n++;
        if (cfg_ready === 1'b0) low++;
        if (tick_os !== m_tick_os || tick_bit !== m_tick_bit || cfg_ready !== m_ready) mm++;
      end
      checks += 3;
      if (n !== exp_first) begin errors++; $display("FAIL clamp%0d_pend_period: got %0d expected %0d", v, n, exp_first); end
      if (low !== n) begin errors++; $display("FAIL clamp%0d_ready_low: got %0d expected %0d", v, low, n); end
      if (mm !== 0) begin errors++; $display("FAIL clamp%0d_model: got %0d diffs expected 0", v, mm); end
      for (int k = 0; k < 3; k++) begin
        wait_evt(1'b0, 20, n, mm);
        checks += 2;
        if (n !== 2) begin errors++; $display("FAIL clamp%0d_interval: got %0d expected 2", v, n); end
        if (mm !== 0) begin errors++; $display("FAIL clamp%0d_interval_model: got %0d diffs expected 0", v, mm); end
      end
      $display("test_div_clamp: cfg_div=%0d interval %0d", v, n);
    end
  endtask

  task automatic test_en_gap();
    int n, mm, bad;
    cfg_valid = 1'b1;
    cfg_div   = 16'd20;
    cfg_frac  = '0;
    @(negedge clk);
    cfg_valid = 1'b0;
    wait_evt(1'b0, 20, n, mm);   // finishes the current 2-cycle period
    wait_evt(1'b0, 40, n, mm);
    checks += 2;
    if (n !== 20) begin errors++; $display("FAIL gap_setup: got %0d expected 20", n); end
    if (mm !== 0) begin errors++; $display("FAIL gap_setup_model: got %0d diffs expected 0", mm); end
    repeat (5) @(negedge clk);
    cfg_valid = 1'b1;            // same divisor, so the nominal tick is well defined
    @(negedge clk);
    cfg_valid = 1'b0;
    checks++;
    if (cfg_ready !== 1'b0) begin errors++; $display("FAIL gap_pend: got %b expected 0", cfg_ready); end
    en  = 1'b0;
    bad = 0;
    repeat (7) begin
      @(negedge clk);
      if (tick_os !== 1'b0 || tick_bit !== 1'b0) bad++;
    end
    checks += 2;
    if (bad !== 0) begin errors++; $display("FAIL gap_no_tick: got %0d ticks expected 0", bad); end
    if (cfg_ready !== 1'b1) begin errors++; $display("FAIL gap_apply: got %b expected 1", cfg_ready); end
    en = 1'b1;
    // Nominal tick was 20 cycles after the last one; 13 have passed, 7 frozen.
    wait_evt(1'b0, 60, n, mm);
    checks += 2;
    if (n !== 20 + 7 - 13) begin errors++; $display("FAIL gap_delay: got %0d expected %0d", n, 20 + 7 - 13); end
    if (mm !== 0) begin errors++; $display("FAIL gap_delay_model: got %0d diffs expected 0", mm); end
    $display("test_en_gap: tick %0d cycles after re-enable", n);
  endtask

  task automatic test_sync_clr();
    int n, mm;
    repeat (19) @(negedge clk);  // one cycle before the expected tick
    sync_clr = 1'b1;
    @(negedge clk);
    checks++;
    if (tick_os !== 1'b0) begin errors++; $display("FAIL clr_no_tick: got %b expected 0", tick_os); end
    sync_clr = 1'b0;
    // Counted from the sample after the clearing edge: d-1, i.e. d after clear.
    wait_evt(1'b0, 60, n, mm);
    checks += 2;
    if (n !== 19) begin errors++; $display("FAIL clr_next_tick: got %0d expected 19", n); end
    if (mm !== 0) begin errors++; $display("FAIL clr_next_tick_model: got %0d diffs expected 0", mm); end
    wait_evt(1'b1, 1000, n, mm);
    checks += 2;
    if (n !== (OS - 1) * 20) begin errors++; $display("FAIL clr_bit: got %0d expected %0d", n, (OS - 1) * 20); end
    if (mm !== 0) begin errors++; $display("FAIL clr_bit_model: got %0d diffs expected 0", mm); end
    $display("test_sync_clr: bit tick %0d cycles after first post-clear tick", n);
  endtask

  task automatic test_reset_pending();
    int n, mm;
    cfg_valid = 1'b1;
    cfg_div   = 16'd5;
    @(negedge clk);
    cfg_valid = 1'b0;
    checks++;
    if (cfg_ready !== 1'b0) begin errors++; $display("FAIL rst_pend: got %b expected 0", cfg_ready); end
    wait_evt(1'b0, 60, n, mm);
    checks++;
    if (n !== 19) begin errors++; $display("FAIL rst_pre_tick: got %0d expected 19", n); end
    reset_n = 1'b0;              // asynchronous, while tick_os is high
    #1;
    checks += 3;
    if (cfg_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b expected 1", cfg_ready); end
    if (tick_os !== 1'b0) begin errors++; $display("FAIL rst_tick_os: got %b expected 0", tick_os); end
    if (tick_bit !== 1'b0) begin errors++; $display("FAIL rst_tick_bit: got %b expected 0", tick_bit); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    // Pending divisor 5 was discarded: the reset divisor is back in force.
    wait_evt(1'b0, 400, n, mm);
    checks += 2;
    if (n !== DIV_RESET - 1) begin errors++; $display("FAIL rst_div: got %0d expected %0d", n, DIV_RESET - 1); end
    if (mm !== 0) begin errors++; $display("FAIL rst_div_model: got %0d diffs expected 0", mm); end
    $display("test_reset_pending: first tick at cycle %0d", n);
  endtask

  task automatic test_random();
    int bad, first, ticks;
    logic [2:0] got, exp;
    reset_n  = 1'b0;
    en       = 1'b1;
    sync_clr = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    bad     = 0;
    first   = -1;
    ticks   = 0;
    got     = '0;
    exp     = '0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (tick_os !== m_tick_os || tick_bit !== m_tick_bit || cfg_ready !== m_ready) begin
        if (bad == 0) begin
          first = c;
          got   = {tick_os, tick_bit, cfg_ready};
          exp   = {m_tick_os, m_tick_bit, m_ready};
        end
        bad++;
      end
      if (tick_os === 1'b1) ticks++;
      en        = ($urandom_range(0, 9) != 0);
      sync_clr  = ($urandom_range(0, 39) == 0);
      cfg_valid = ($urandom_range(0, 7) == 0);
      cfg_div   = DIV_W'($urandom_range(0, 7));
      cfg_frac  = FRAC_W'($urandom);
    end
    en        = 1'b1;
    sync_clr  = 1'b0;
    cfg_valid = 1'b0;
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL random_model: %0d diffs, first at cycle %0d got os/bit/rdy=%b expected %b", bad, first, got, exp);
    end
    $display("test_random: 3000 cycles, %0d ticks, %0d diffs", ticks, bad);
  endtask

  initial begin
    test_reset();
    test_default_rate();
    test_frac_cfg();
    test_div_clamp();
    test_en_gap();
    test_sync_clr();
    test_reset_pending();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
